regfile_write_arbiter: RTL and testbench

Merges register-file write traffic into the single GPR write port: the pipeline writeback stage and the multi-cycle MultDiv result path. Pipeline writes have priority. MultDiv results are buffered in a small FIFO and drained in idle writeback slots. The block drives `RegWrite`/`write_reg`/`write_data` into the register file. It also exports a pending-destination scoreboard, which the decode stage uses to stall RAW/WAW hazards on outstanding MultDiv results.

---
 rtl/regfile_write_arbiter_if.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the register-file write arbiter's handshake and bus signals.
//
//   master : pipeline writeback / MultDiv source side. Drives the wb and md
//            request fields, observes md_ready, the register-file write port,
//            the pending-destination mask and wb_stall.
//   slave  : the arbiter itself.
//
// Handshake: an MultDiv result moves into the arbiter on a rising clock edge
// where md_valid && md_ready. md_ready depends only on registered state. The
// master may hold md_valid and the md fields until the transfer completes.
// wb_valid is a single-cycle request with no back-pressure, except that it
// must be 0 in any cycle where wb_stall is 1.
interface regfile_write_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pend_mask;
  logic        wb_stall;

  modport master (
    output wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data,
    input  md_ready, RegWrite, write_reg, write_data, pend_mask, wb_stall
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data,
    output md_ready, RegWrite, write_reg, write_data, pend_mask, wb_stall
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Merges pipeline writeback and MultDiv results onto the single GPR write
//   port. Pipeline writes win. MultDiv results wait in a DEPTH-entry FIFO and
//   drain in slots where the pipeline is not writing. The block also exports
//   pend_mask, which shows every destination that is queued or in the output
//   stage, so decode can stall on hazards.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : regfile_write_arbiter_if.slave
//          (wb_*, md_* requests, md_ready, RegWrite/write_reg/write_data,
//           pend_mask, wb_stall)
//
// Parameters
//   DEPTH      : FIFO entries. Must be a power of two and at least 2.
//   STARVE_MAX : number of consecutive cycles the FIFO may be blocked before
//                a forced drain. Used only when the guard is built in.
//
// Build option
//   REGWB_STARVE_GUARD_EN : when defined, a starvation counter is built in.
//   When it fires, wb_stall is raised for one cycle and the FIFO head is
//   popped in that cycle. When undefined, wb_stall is tied to 0 and pipeline
//   writes have strict priority.
module regfile_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_param
    $error("regfile_write_arbiter: DEPTH must be a power of two >= 2, STARVE_MAX >= 1");
  end

  // FIFO state
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [4:0]    reg_mem_q  [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  // Output stage
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;

  logic          stall_q;
  logic          fifo_empty;
  logic          wb_req;
  logic          push;
  logic          pop;
  logic          load_wb;

  assign fifo_empty = (count_q == '0);
  assign bus.md_ready = (count_q != (PW+1)'(DEPTH));
  // A wb write to r0 is not a real request and must not block the FIFO.
  assign wb_req = bus.wb_valid && (bus.wb_reg != 5'd0);
  // An r0 push completes the handshake but is not stored.
  assign push = bus.md_valid && bus.md_ready && (bus.md_reg != 5'd0);

  // Selection for this cycle's output-stage load.
  always_comb begin
    pop     = 1'b0;
    load_wb = 1'b0;
    if (stall_q) begin
      // wb_valid during a stall is a protocol violation and is ignored.
      pop = !fifo_empty;
    end else if (wb_req) begin
      load_wb = 1'b1;
    end else begin
      pop = !fifo_empty;
    end
  end

  always_comb begin
    reg_write_d  = load_wb || pop;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (load_wb) begin
      write_reg_d  = bus.wb_reg;
      write_data_d = bus.wb_data;
    end else if (pop) begin
      write_reg_d  = reg_mem_q[rd_ptr_q];
      write_data_d = data_mem_q[rd_ptr_q];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) reg_mem_q[i] <= 5'd0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      if (push) reg_mem_q[wr_ptr_q] <= bus.md_reg;
    end
  end

  // Data payload needs no reset: an entry is only read when count marks it valid.
  always_ff @(posedge clk) begin
    if (push) data_mem_q[wr_ptr_q] <= bus.md_data;
  end

`ifdef REGWB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_d;

  // Counts cycles in which a non-empty FIFO loses to wb. The stall flop is
  // raised on the edge where the count reaches STARVE_MAX, so wb_stall is
  // high in the cycle after the STARVE_MAX-th blocked cycle.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (load_wb) begin
      if (starve_q == SW'(STARVE_MAX - 1)) begin
        stall_d  = 1'b1;
        starve_d = '0;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  // Pending-destination mask, computed only from registered state.
  logic [31:0]   pend;
  logic [PW-1:0] offset;
  always_comb begin
    pend   = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q) pend[reg_mem_q[i]] = 1'b1;
    end
    if (reg_write_q) pend[write_reg_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.pend_mask  = pend;
  assign bus.RegWrite   = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.wb_stall   = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // exp_q holds {reg, data} of queued MultDiv results in arrival order.
  logic [36:0] exp_q[$];
  logic        m_rw    = 1'b0;
  logic [4:0]  m_wr    = 5'd0;
  logic [31:0] m_wd    = 32'd0;
  logic        m_stall = 1'b0;
  int          m_starve = 0;
  int          m_n;
  bit          m_pop, m_won;
  logic [36:0] m_head;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
      m_stall = 1'b0; m_starve = 0;
    end else begin
      m_n   = exp_q.size();
      m_pop = 1'b0;
      m_won = 1'b0;
      if (m_stall && m_n > 0) m_pop = 1'b1;
      else if (!m_stall && bus.wb_valid && bus.wb_reg != 5'd0) m_won = 1'b1;
      else if (m_n > 0) m_pop = 1'b1;

      if (m_won) begin
        m_rw = 1'b1; m_wr = bus.wb_reg; m_wd = bus.wb_data;
      end else if (m_pop) begin
        m_head = exp_q.pop_front();
        m_rw = 1'b1; m_wr = m_head[36:32]; m_wd = m_head[31:0];
      end else begin
        m_rw = 1'b0;
      end

      if (m_n != DEPTH && bus.md_valid && bus.md_reg != 5'd0)
        exp_q.push_back({bus.md_reg, bus.md_data});

`ifdef REGWB_STARVE_GUARD_EN
      m_stall = 1'b0;
      if (m_pop || m_n == 0) m_starve = 0;
      else if (m_won) begin
        m_starve++;
        if (m_starve == STARVE_MAX) begin
          m_stall  = 1'b1;
          m_starve = 0;
        end
      end
`endif
    end
  end

  function automatic logic [31:0] exp_pend();
    logic [31:0] p = '0;
    foreach (exp_q[i]) p[exp_q[i][36:32]] = 1'b1;
    if (m_rw) p[m_wr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("RegWrite",   32'(bus.RegWrite),  32'(m_rw));
      chk("write_reg",  32'(bus.write_reg), 32'(m_wr));
      chk("write_data", bus.write_data,     m_wd);
      chk("md_ready",   32'(bus.md_ready),  32'(exp_q.size() != DEPTH));
      chk("pend_mask",  bus.pend_mask,      exp_pend());
      chk("wb_stall",   32'(bus.wb_stall),  32'(m_stall));
    end
  end

  // Retirement monitor for ordering checks.
  bit         collect = 1'b0;
  logic [4:0] seen_q[$];
  always @(negedge clk) begin
    if (collect && !rst && bus.RegWrite && bus.write_reg != 5'd7) seen_q.push_back(bus.write_reg);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic md_push(input logic [4:0] r, input logic [31:0] d);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    bus.md_valid = 1'b1; bus.md_reg = r; bus.md_data = d;
    while (!acc && t < 40) begin
      acc = bus.md_ready;
      cyc();
      t++;
    end
    bus.md_valid = 1'b0;
    if (!acc) chk("md_push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_hold(input logic on, input logic [4:0] r, input logic [31:0] d);
    bus.wb_valid = on; bus.wb_reg = r; bus.wb_data = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.wb_valid = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = 32'd0;
    bus.md_valid = 1'b0; bus.md_reg = 5'd0; bus.md_data = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_RegWrite",  32'(bus.RegWrite), 32'd0);
    chk("rst_md_ready",  32'(bus.md_ready), 32'd1);
    chk("rst_pend_mask", bus.pend_mask,     32'd0);
    rst = 1'b0;
    cyc();

    // Single wb write.
    wb_hold(1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    wb_hold(1'b0, 5'd0, 32'd0);
    chk("wb_RegWrite",   32'(bus.RegWrite),  32'd1);
    chk("wb_write_reg",  32'(bus.write_reg), 32'd5);
    chk("wb_write_data", bus.write_data,     32'hDEADBEEF);
    chk("wb_pend_mask",  bus.pend_mask,      32'h0000_0020);
    cyc();
    chk("wb_one_cycle",  32'(bus.RegWrite),  32'd0);
    chk("wb_addr_hold",  32'(bus.write_reg), 32'd5);

    // Fill and wrap: r1..r6 while wb holds r7.
    wb_hold(1'b1, 5'd7, 32'h7777_7777);
    for (int k = 1; k <= 4; k++) md_push(5'(k), $urandom);
    chk("fill_md_ready", 32'(bus.md_ready), 32'd0);
    seen_q.delete();
    collect = 1'b1;
    wb_hold(1'b0, 5'd0, 32'd0);
    md_push(5'd5, $urandom);
    md_push(5'd6, $urandom);
    repeat (8) cyc();
    collect = 1'b0;
    chk("wrap_count", 32'(seen_q.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      chk("wrap_order", (k < seen_q.size()) ? 32'(seen_q[k]) : 32'hFFFF_FFFF, 32'(k + 1));

    // Register 0 handling.
    wb_hold(1'b1, 5'd3, 32'h3333_3333);
    md_push(5'd9, 32'h0000_0909);
    bus.wb_reg = 5'd0;
    cyc();
    wb_hold(1'b0, 5'd0, 32'd0);
    chk("r0_wb_slot_reg",  32'(bus.write_reg), 32'd9);
    chk("r0_wb_slot_data", bus.write_data,     32'h0000_0909);
    chk("r0_wb_slot_pend", bus.pend_mask,      32'h0000_0200);
    md_push(5'd0, 32'h1234_5678);
    chk("r0_md_RegWrite",  32'(bus.RegWrite),  32'd0);
    chk("r0_md_pend",      bus.pend_mask,      32'd0);
    chk("r0_md_ready",     32'(bus.md_ready),  32'd1);
    cyc();

    // Simultaneous push and pop at count 2.
    wb_hold(1'b1, 5'd3, 32'h3333_3333);
    md_push(5'd10, 32'h0000_0A0A);
    md_push(5'd11, 32'h0000_0B0B);
    wb_hold(1'b0, 5'd0, 32'd0);
    md_push(5'd12, 32'h0000_0C0C);
    chk("pp_write_reg", 32'(bus.write_reg), 32'd10);
    chk("pp_pend_mask", bus.pend_mask,      32'h0000_1C00);
    repeat (4) cyc();

    // Starvation behaviour with one queued entry.
    wb_hold(1'b1, 5'd3, 32'h3333_3333);
    md_push(5'd13, 32'h0000_0D0D);
`ifdef REGWB_STARVE_GUARD_EN
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 7) chk("guard_pre_stall", 32'(bus.wb_stall), 32'd0);
      if (i == 8) chk("guard_stall",     32'(bus.wb_stall), 32'd1);
    end
    cyc();
    chk("guard_retire",  32'(bus.write_reg), 32'd13);
    chk("guard_release", 32'(bus.wb_stall),  32'd0);
    wb_hold(1'b0, 5'd0, 32'd0);
`else
    repeat (20) cyc();
    chk("starve_pend",  bus.pend_mask,       32'h0000_2008);
    chk("starve_stall", 32'(bus.wb_stall),   32'd0);
    wb_hold(1'b0, 5'd0, 32'd0);
    cyc();
    chk("starve_retire", 32'(bus.write_reg), 32'd13);
`endif
    repeat (3) cyc();

    // Randomized traffic: moderate, then heavy wb pressure.
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 400; c++) begin
        bus.wb_valid = ($urandom_range(0, 99) < ((ph == 0) ? 55 : 95));
        bus.wb_reg   = 5'($urandom_range(0, 31));
        bus.wb_data  = $urandom;
        bus.md_valid = ($urandom_range(0, 99) < 50);
        bus.md_reg   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.md_data  = $urandom;
        cyc();
      end
      wb_hold(1'b0, 5'd0, 32'd0);
      bus.md_valid = 1'b0;
      repeat (8) cyc();
    end

    // Reset mid-drain with three entries queued.
    wb_hold(1'b1, 5'd3, 32'h3333_3333);
    md_push(5'd20, $urandom);
    md_push(5'd21, $urandom);
    md_push(5'd22, $urandom);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_RegWrite",   32'(bus.RegWrite),  32'd0);
    chk("mid_rst_write_reg",  32'(bus.write_reg), 32'd0);
    chk("mid_rst_write_data", bus.write_data,     32'd0);
    chk("mid_rst_md_ready",   32'(bus.md_ready),  32'd1);
    chk("mid_rst_pend_mask",  bus.pend_mask,      32'd0);
    chk("mid_rst_wb_stall",   32'(bus.wb_stall),  32'd0);
    wb_hold(1'b0, 5'd0, 32'd0);
    cyc();
    rst = 1'b0;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
